// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl
//   Multi-cycle sequencer for an RV32I datapath. It steps each instruction through
//   FETCH / DECODE / EXEC / MEM / WB. In DECODE it latches an opcode class, and the
//   datapath strobes are then decoded from that class. It runs the imem/dmem req/ready
//   handshakes, counts retired instructions, and parks in HALT on SYSTEM. It parks in
//   TRAP on an illegal opcode or on a bus that never answers.
//
// Ports
//   clk_i            core clock, rising edge
//   rst_i            synchronous active-high reset; forces every output low while high
//   instruction_i    IR contents, stable from DECODE until the next FETCH
//   branch_taken_i   ALU compare result, used in EXEC for branches
//   imem_ready_i     instruction memory data valid
//   dmem_ready_i     data memory access complete
//   imem_req_o       instruction fetch request
//   dmem_req_o       data memory request
//   dmem_we_o        data memory write (store), valid with dmem_req_o
//   ir_we_o          load IR
//   pc_we_o          update PC (also marks retirement)
//   pc_sel_o         00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
//   reg_we_o         register file write
//   wb_sel_o         00 ALU, 01 load data, 10 PC+4, 11 imm
//   alu_src_a_o      0 rs1, 1 PC
//   alu_src_b_o      0 rs2, 1 imm
//   instret_o        retired instruction count, wraps
//   halted_o         sticky: SYSTEM opcode reached
//   trap_o           sticky: illegal opcode or bus timeout
//   bus_err_o        sticky: trap was a bus timeout (0 = illegal opcode)
//
// state  | meaning
// FETCH  | imem_req high until imem_ready; IR loaded in the ready cycle
// DECODE | opcode classified and latched
// EXEC   | ALU operands selected; branches resolve and retire here
// MEM    | dmem_req high until dmem_ready; stores retire on ready
// WB     | register write-back, PC update, retire
// HALT   | SYSTEM reached, absorbing until reset
// TRAP   | illegal opcode or bus timeout, absorbing until reset

module multi_cycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          instruction_i,
  input  logic                 branch_taken_i,
  input  logic                 imem_ready_i,
  input  logic                 dmem_ready_i,
  output logic                 imem_req_o,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic                 ir_we_o,
  output logic                 pc_we_o,
  output logic [1:0]           pc_sel_o,
  output logic                 reg_we_o,
  output logic [1:0]           wb_sel_o,
  output logic                 alu_src_a_o,
  output logic                 alu_src_b_o,
  output logic [INSTRET_W-1:0] instret_o,
  output logic                 halted_o,
  output logic                 trap_o,
  output logic                 bus_err_o
);

  localparam int unsigned TMR_W = $clog2(MEM_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_t;

  state_t state_q, state_d;
  cls_t   cls_q, cls_d;
  logic [TMR_W-1:0]     tmr_q;
  logic [INSTRET_W-1:0] instret_q;
  logic                 bus_err_q;

  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
  logic       alu_src_a, alu_src_b;
  logic [1:0] pc_sel, wb_sel;
  logic       req_wait, tmr_zero, timeout_hit;

  // Only the opcode field is ever looked at.
  logic unused_instr;
  assign unused_instr = ^instruction_i[31:7];

  assign req_wait    = (state_q == S_FETCH && !imem_ready_i) ||
                       (state_q == S_MEM   && !dmem_ready_i);
  assign tmr_zero    = (tmr_q == '0);
  assign timeout_hit = req_wait && tmr_zero;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      cls_q     <= C_R;
      tmr_q     <= TMR_LOAD;
      instret_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      // Down-counter reloads on every state change; it only runs in FETCH/MEM,
      // so in effect it restarts on entry to either wait state.
      if (state_d != state_q) begin
        tmr_q <= TMR_LOAD;
      end else if (req_wait) begin
        tmr_q <= tmr_q - TMR_W'(1);
      end
      if (pc_we) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
      if (timeout_hit) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'b00;
    reg_we    = 1'b0;
    wb_sel    = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready_i) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (tmr_zero) begin
          state_d = S_TRAP;
        end
      end

      S_DECODE: begin
        state_d = S_EXEC;
        case (instruction_i[6:0])
          7'b0110011: cls_d = C_R;
          7'b0010011: cls_d = C_IALU;
          7'b0000011: cls_d = C_LOAD;
          7'b0100011: cls_d = C_STORE;
          7'b1100011: cls_d = C_BRANCH;
          7'b1101111: cls_d = C_JAL;
          7'b1100111: cls_d = C_JALR;
          7'b0110111: cls_d = C_LUI;
          7'b0010111: cls_d = C_AUIPC;
          7'b1110011: state_d = S_HALT;
          default:    state_d = S_TRAP;
        endcase
      end

      S_EXEC: begin
        alu_src_a = (cls_q == C_AUIPC);
        alu_src_b = !(cls_q == C_R || cls_q == C_BRANCH);
        if (cls_q == C_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken_i ? 2'b01 : 2'b00;
          state_d = S_FETCH;
        end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
        // Ready in the terminal-count cycle still completes the access.
        if (dmem_ready_i) begin
          if (cls_q == C_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (tmr_zero) begin
          state_d = S_TRAP;
        end
      end

      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        case (cls_q)
          C_LOAD:        wb_sel = 2'b01;
          C_JAL, C_JALR: wb_sel = 2'b10;
          C_LUI:         wb_sel = 2'b11;
          default:       wb_sel = 2'b00;
        endcase
        case (cls_q)
          C_JAL:   pc_sel = 2'b01;
          C_JALR:  pc_sel = 2'b10;
          default: pc_sel = 2'b00;
        endcase
      end

      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Reset has priority over everything, including an access in flight,
  // so every output is forced low while rst_i is high.
  assign imem_req_o  = imem_req  & ~rst_i;
  assign dmem_req_o  = dmem_req  & ~rst_i;
  assign dmem_we_o   = dmem_we   & ~rst_i;
  assign ir_we_o     = ir_we     & ~rst_i;
  assign pc_we_o     = pc_we     & ~rst_i;
  assign pc_sel_o    = rst_i ? 2'b00 : pc_sel;
  assign reg_we_o    = reg_we    & ~rst_i;
  assign wb_sel_o    = rst_i ? 2'b00 : wb_sel;
  assign alu_src_a_o = alu_src_a & ~rst_i;
  assign alu_src_b_o = alu_src_b & ~rst_i;
  assign instret_o   = rst_i ? '0 : instret_q;
  assign halted_o    = (state_q == S_HALT) & ~rst_i;
  assign trap_o      = (state_q == S_TRAP) & ~rst_i;
  assign bus_err_o   = bus_err_q & ~rst_i;

endmodule
